// File: rtl/music_pkg.sv
// rtl/music_pkg.sv - shared loader state, word geometry and player bus widths
package music_pkg;

  // Bytes packed into one song word
  localparam int WORD_BYTES = 4;

  // Player request/response bus widths
  localparam int MEMREQ_ADDR_W  = 16;
  localparam int MEMRESP_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } loader_state_t;

endpackage

// File: rtl/music_mem_loader_if.sv
// rtl/music_mem_loader_if.sv - player song-memory read request bus
interface music_mem_loader_if;
  import music_pkg::*;

  logic                      memreq_val;
  logic [MEMREQ_ADDR_W-1:0]  memreq_addr;
  logic [MEMRESP_DATA_W-1:0] memresp_data;

  // Player side issues requests
  modport master (
    output memreq_val,
    output memreq_addr,
    input  memresp_data
  );

  // Song memory answers them
  modport slave (
    input  memreq_val,
    input  memreq_addr,
    output memresp_data
  );

endinterface

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - little-endian byte-to-word assembler with zero-padded flush
module byte_packer
  import music_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      byte_val,
  input  logic [7:0]                byte_data,
  input  logic                      flush,
  output logic                      word_val,
  output logic [MEMRESP_DATA_W-1:0] word_data
);

  localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

  logic [MEMRESP_DATA_W-1:0] shift_q;
  logic [1:0]                cnt_q;
  logic [MEMRESP_DATA_W-1:0] lane_word;

  // Place the incoming byte in its lane; the word on word_data already includes it
  always_comb begin
    lane_word = '0;
    word_data = shift_q;
    word_val  = 1'b0;
    lane_word = MEMRESP_DATA_W'(byte_data) << {cnt_q, 3'b000};
    if (byte_val) begin
      word_data = shift_q | lane_word;
    end
    // Emit on the last lane, or on flush if anything is pending (including this cycle's byte)
    word_val = (byte_val && (cnt_q == LAST_LANE)) ||
               (flush && ((cnt_q != 2'd0) || byte_val));
  end

  // Shift register and lane counter; a committed word leaves the register empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
    end else if (clear || word_val) begin
      shift_q <= '0;
      cnt_q   <= 2'd0;
    end else if (byte_val) begin
      shift_q <= word_data;
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/music_mem_loader.sv
// rtl/music_mem_loader.sv - run-time loadable song memory serving player read requests
module music_mem_loader
  import music_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  music_mem_loader_if.slave    mem_if,
  input  logic                 load_start,
  input  logic                 load_done,
  input  logic                 in_val,
  input  logic [7:0]           in_byte,
  output logic                 in_rdy,
  output logic                 busy,
  output logic                 full,
  output logic [ADDR_BITS:0]   word_count
);

  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

  loader_state_t state_q, state_d;
  logic [ADDR_BITS:0]          count_q;
  logic [MEMRESP_DATA_W-1:0]   mem [DEPTH];

  logic                        pk_byte_val;
  logic                        pk_flush;
  logic                        pk_word_val;
  logic [MEMRESP_DATA_W-1:0]   pk_word_data;

  logic [ADDR_BITS-1:0]        rd_idx;
  logic                        rd_hit;
  logic                        unused_addr;

  // A restart wins over both the end-of-stream marker and any byte offered that cycle
  always_comb begin
    pk_byte_val = (state_q == ST_LOAD) && in_val && !load_start;
    pk_flush    = (state_q == ST_LOAD) && load_done && !load_start;
  end

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_start),
    .byte_val  (pk_byte_val),
    .byte_data (in_byte),
    .flush     (pk_flush),
    .word_val  (pk_word_val),
    .word_data (pk_word_data)
  );

  // Loader state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and status outputs
  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    busy    = 1'b0;
    full    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        in_rdy = 1'b1;
        busy   = 1'b1;
        if (load_start) begin
          state_d = ST_LOAD;
        end else if (pk_word_val && (count_q == DEPTH_W - 1'b1)) begin
          state_d = ST_FULL;
        end else if (load_done) begin
          state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        full = 1'b1;
        if (load_start) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Committed word count doubles as the write pointer; it never passes DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load_start) begin
      count_q <= '0;
    end else if (pk_word_val && (count_q != DEPTH_W)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Song array write; contents survive reset and restarts but are hidden by count_q
  always_ff @(posedge clk) begin
    if (pk_word_val) begin
      mem[count_q[ADDR_BITS-1:0]] <= pk_word_data;
    end
  end

  // Zero-latency read; words not yet committed read back as zero
  always_comb begin
    rd_idx              = mem_if.memreq_addr[ADDR_BITS+1:2];
    rd_hit              = mem_if.memreq_val && ({1'b0, rd_idx} < count_q);
    mem_if.memresp_data = rd_hit ? mem[rd_idx] : '0;
  end

  assign unused_addr = ^{mem_if.memreq_addr[1:0],
                         mem_if.memreq_addr[MEMREQ_ADDR_W-1:ADDR_BITS+2]};
  assign word_count  = count_q;

endmodule

// File: tb/tb_music_mem_loader.sv
// tb/tb_music_mem_loader.sv - randomized and directed checks of music_mem_loader against a queue model
module tb_music_mem_loader;

  localparam int DEPTH = 4;
  localparam int AB    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          load_start = 1'b0;
  logic          load_done  = 1'b0;
  logic          in_val     = 1'b0;
  logic [7:0]    in_byte    = 8'h00;
  logic          in_rdy, busy, full;
  logic [AB:0]   word_count;

  music_mem_loader_if mif();

  music_mem_loader #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .mem_if     (mif),
    .load_start (load_start),
    .load_done  (load_done),
    .in_val     (in_val),
    .in_byte    (in_byte),
    .in_rdy     (in_rdy),
    .busy       (busy),
    .full       (full),
    .word_count (word_count)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 loading, 2 full; pending bytes queue; committed words list
  int          m_mode = 0;
  int          m_count = 0;
  logic [7:0]  m_pend[$];
  logic [31:0] m_words[DEPTH];

  function automatic logic [31:0] pack_pend();
    logic [31:0] w = 32'h0;
    for (int i = 0; i < m_pend.size(); i++) w = w + (32'(m_pend[i]) << (8 * i));
    return w;
  endfunction

  task automatic commit_pend();
    m_words[m_count] = pack_pend();
    m_count++;
    m_pend.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_count = 0; m_pend.delete();
    end else if (load_start) begin
      m_mode = 1; m_count = 0; m_pend.delete();
    end else if (m_mode == 1) begin
      if (in_val) m_pend.push_back(in_byte);
      if (m_pend.size() == 4) begin
        commit_pend();
        if (m_count == DEPTH) m_mode = 2;
        else if (load_done) m_mode = 0;
      end else if (load_done) begin
        if (m_pend.size() > 0) commit_pend();
        m_mode = (m_count == DEPTH) ? 2 : 0;
      end
    end
  end

  function automatic logic [31:0] exp_resp();
    int idx = int'(mif.memreq_addr[15:2]) % DEPTH;
    if (mif.memreq_val && idx < m_count) return m_words[idx];
    return 32'h0;
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_rdy", in_rdy, m_mode == 1);
      check("busy", busy, m_mode == 1);
      check("full", full, m_mode == 2);
      check("word_count", word_count, m_count);
      check("memresp_data", mif.memresp_data, exp_resp());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    load_start = 1'b0;
    load_done  = 1'b0;
    in_val     = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_val = 1'b1; in_byte = b;
    tick();
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [31:0] exp);
    mif.memreq_val = 1'b1; mif.memreq_addr = a;
    #2;
    check(name, mif.memresp_data, exp);
    tick();
  endtask

  logic [7:0] basic_bytes[8];

  initial begin
    mif.memreq_val = 1'b1; mif.memreq_addr = 16'h0;
    basic_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    repeat (3) @(posedge clk);
    #3;
    check("rst_resp", mif.memresp_data, 32'h0);
    check("rst_wc", word_count, 0);
    check("rst_in_rdy", in_rdy, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    chk_en = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // Basic two-word load
    load_start = 1'b1; tick();
    foreach (basic_bytes[i]) send(basic_bytes[i]);
    load_done = 1'b1; tick();
    #2;
    check("basic_wc", word_count, 2);
    check("basic_busy", busy, 1'b0);
    tick();
    rd_check("basic_a0", 16'd0, 32'h44332211);
    rd_check("basic_a4", 16'd4, 32'h88776655);
    rd_check("basic_a8", 16'd8, 32'h0);
    rd_check("basic_a2", 16'd2, 32'h44332211);
    rd_check("basic_alias", 16'd16, 32'h44332211);

    // Partial word flush
    load_start = 1'b1; tick();
    send(8'hAA); send(8'hBB); send(8'hCC);
    load_done = 1'b1; tick();
    #2;
    check("part_wc", word_count, 1);
    check("part_busy", busy, 1'b0);
    check("part_full", full, 1'b0);
    tick();
    rd_check("part_a0", 16'd0, 32'h00CCBBAA);

    // Fill all DEPTH words
    load_start = 1'b1; tick();
    for (int i = 0; i < 16; i++) send(8'(i * 17));
    #2;
    check("full_full", full, 1'b1);
    check("full_in_rdy", in_rdy, 1'b0);
    check("full_wc", word_count, 4);
    tick();
    send(8'h5A);
    #2;
    check("full_17th_wc", word_count, 4);
    tick();
    load_done = 1'b1; tick();
    #2;
    check("full_done_ignored", full, 1'b1);
    tick();
    rd_check("full_a12", 16'd12, 32'hFFEEDDCC);
    rd_check("full_a0", 16'd0, 32'h33221100);
    load_start = 1'b1; tick();
    #2;
    check("restart_busy", busy, 1'b1);
    check("restart_wc", word_count, 0);
    tick();

    // Gapped bytes and same-cycle read of the committing word
    mif.memreq_val = 1'b1; mif.memreq_addr = 16'd0;
    send(8'h01);
    in_byte = 8'h99; tick();
    send(8'h02);
    in_byte = 8'h77; tick();
    send(8'h03);
    in_val = 1'b1; in_byte = 8'h04;
    #2;
    check("collide_same_cycle", mif.memresp_data, 32'h0);
    tick();
    #2;
    check("collide_next_cycle", mif.memresp_data, 32'h04030201);
    check("collide_wc", word_count, 1);
    tick();

    // Restart mid-word discards the partial bytes
    send(8'hAA); send(8'hBB);
    load_start = 1'b1; in_val = 1'b1; in_byte = 8'hEE; tick();
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    #2;
    check("mid_restart_wc", word_count, 1);
    tick();
    rd_check("mid_restart_a0", 16'd0, 32'h40302010);

    // Asynchronous reset mid-load
    send(8'h50); send(8'h60);
    #2; rst_n = 1'b0; #1;
    check("arst_busy", busy, 1'b0);
    check("arst_wc", word_count, 0);
    check("arst_in_rdy", in_rdy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      load_start = ($urandom % 40) == 0;
      load_done  = ($urandom % 16) == 0;
      in_val     = $urandom % 2;
      in_byte    = 8'($urandom);
      mif.memreq_val  = ($urandom % 4) != 0;
      mif.memreq_addr = ($urandom % 4 == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      if ($urandom % 400 == 0) begin
        #2; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/music_mem_loader.md
Name: music_mem_loader

Overview:
- Song memory that is the responder end of the player's memreq_val/memreq_addr/memresp_data request interface.
- Adds a byte-stream load port, so songs are written at run time (from a host or UART front end) instead of being fixed contents.
- Sits between the loader front end and the music player; read and load paths operate concurrently.

Parameters:
- DEPTH, 256, number of 32-bit song words (power of two, >=4)
- ADDR_BITS, 8, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- memreq_val  in  1  read request valid
- memreq_addr  in  16  byte address of the requested word
- memresp_data  out  32  read data
- load_start  in  1  pulse: begin new song load, clears memory occupancy
- load_done  in  1  pulse: end of song stream
- in_val  in  1  load byte valid
- in_byte  in  8  load byte
- in_rdy  out  1  load byte accepted when in_val&in_rdy
- busy  out  1  loader in LOAD state
- full  out  1  loader in FULL state
- word_count  out  ADDR_BITS+1  committed words

Behaviour:
- Reset (rst=0, async): state=IDLE, wr_ptr=0, byte_cnt=0, shift reg=0, word_count=0, in_rdy=0, busy=0, full=0. The memory array is not reset.
- Read path (combinational, zero latency, matching the player's expectation):
  - idx = memreq_addr[ADDR_BITS+1:2]; memreq_addr[1:0] and bits above ADDR_BITS+1 are ignored.
  - memresp_data = mem[idx] if memreq_val && idx < word_count; otherwise 32'h0.
- Read/write collision: a read of the word committed in the same cycle returns 0 for that cycle, because word_count updates at the clock edge; the new data is visible the next cycle.
- FSM IDLE / LOAD / FULL:
  - IDLE: in_rdy=0. load_start -> LOAD; wr_ptr=0, byte_cnt=0, word_count=0.
  - LOAD: in_rdy=1, busy=1.
    - Accepted byte goes into shift reg lane byte_cnt (little-endian: first byte -> [7:0]); byte_cnt++.
    - On the 4th byte: mem[wr_ptr] <= assembled word (including the current byte); wr_ptr++, word_count++, byte_cnt=0, shift reg cleared.
    - When that commit makes wr_ptr==DEPTH -> FULL.
  - LOAD + load_done:
    - If byte_cnt!=0, or a byte is accepted that same cycle, the partial word is written zero-padded in the upper lanes and counted.
    - Then -> IDLE.
    - If that write fills memory -> FULL.
  - FULL: in_rdy=0, full=1; bytes are not accepted; load_done ignored. load_start -> LOAD with a restart (as in IDLE).
- Priority: load_start overrides load_done and any in_val in the same cycle. A restart mid-LOAD discards the partial word; previously written words become unreadable (word_count=0).
- word_count saturates at DEPTH, with width ADDR_BITS+1 so DEPTH is representable.
- Reset mid-load returns to IDLE; memory contents are retained but unreadable because word_count=0.

Decomposition:
- Shared package music_pkg holds:
  - loader state enum (IDLE, LOAD, FULL)
  - WORD_BYTES=4 constant
  - memreq/memresp width constants (16-bit address, 32-bit data), shared with the player
- One natural sub-module: byte_packer (shift reg + byte_cnt, emits word_val/word_data, supports flush with zero pad).
- The array and FSM stay in the top.

Test Plan:
- Reset then read: rst low, memreq_val=1, addr=0 -> memresp_data=0, word_count=0, in_rdy=0.
- Basic load:
  - load_start, bytes 11,22,33,44,55,66,77,88, then load_done -> word_count=2.
  - addr 0 -> 32'h44332211; addr 4 -> 32'h88776655; addr 8 -> 0.
  - addr 2 -> 32'h44332211 (low bits ignored).
- Partial flush: load_start, bytes AA,BB,CC, load_done -> word_count=1, addr 0 -> 32'h00CCBBAA, state IDLE.
- Full (DEPTH=4): load 16 bytes -> full=1 and in_rdy=0 after the 16th; 17th byte with in_val=1 is not accepted; load_done ignored; load_start -> busy=1, word_count=0.
- Collision/backpressure:
  - in_val with gaps -> only handshaken bytes are packed.
  - Reading addr 0 in the cycle its word commits -> 0; next cycle -> committed data.
- Restart mid-load and async reset: 2 bytes then load_start -> byte_cnt cleared, next 4 bytes form word 0. rst asserted mid-LOAD (off a clock edge) -> busy=0 immediately, word_count=0.
